// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM frame demultiplexer.
// Holds the FSM state enum and the slot-index width helper.
package tdm_pkg;

    localparam int N_CH_DEF   = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Slot stream in, frame bus out, for the TDM demultiplexer.
// master drives slot words; slave is the demultiplexer.
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH_W   = ch_w(N_CH)
) ();

    logic                     in_valid;
    logic                     in_sof;
    logic [DATA_W-1:0]        in_data;
    logic [N_CH*DATA_W-1:0]   out_data;
    logic                     out_valid;
    logic                     frame_err;
    logic [CH_W-1:0]          ch_idx;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_data, out_valid, frame_err, ch_idx
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_data, out_valid, frame_err, ch_idx
    );

endinterface

// File: rtl/tdm_slot_dec.sv
// One-hot shadow write-enable decoder for the TDM demultiplexer.
module tdm_slot_dec #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            en,
    input  logic [CH_W-1:0] slot,
    output logic [N_CH-1:0] we
);

    always_comb begin
        we = '0;
        for (int k = 0; k < N_CH; k++) begin
            we[k] = en && (slot == CH_W'(k));
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: collects N_CH slot words into a shadow
// frame and publishes it on out_data when the last slot arrives.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH_W   = ch_w(N_CH)
) (
    input logic       clk,
    input logic       rst,
    tdm_demux_if.slave bus
);

    localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);

    state_t                   state, state_nxt;
    logic [CH_W-1:0]          ch_q, ch_nxt;
    logic [N_CH*DATA_W-1:0]   shadow, shadow_nxt;
    logic [N_CH*DATA_W-1:0]   frame_q;
    logic                     valid_q, err_q;
    logic                     wr, done, err;
    logic [CH_W-1:0]          slot;
    logic [N_CH-1:0]          we;

    tdm_slot_dec #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_dec (
        .en   (wr),
        .slot (slot),
        .we   (we)
    );

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_q;
        wr        = 1'b0;
        slot      = '0;
        done      = 1'b0;
        err       = 1'b0;
        if (bus.in_valid) begin
            unique case (state)
                IDLE: begin
                    if (bus.in_sof) begin
                        wr = 1'b1;
                        if (N_CH == 1) begin
                            done = 1'b1;
                        end else begin
                            ch_nxt    = CH_W'(1);
                            state_nxt = RUN;
                        end
                    end else begin
                        err = 1'b1;
                    end
                end
                RUN: begin
                    wr = 1'b1;
                    // short frame: restart on the new slot 0
                    if (bus.in_sof) begin
                        err    = 1'b1;
                        ch_nxt = CH_W'(1);
                    end else begin
                        slot = ch_q;
                        if (ch_q == LAST) begin
                            done      = 1'b1;
                            ch_nxt    = '0;
                            state_nxt = IDLE;
                        end else begin
                            ch_nxt = ch_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        shadow_nxt = shadow;
        for (int k = 0; k < N_CH; k++) begin
            if (we[k]) shadow_nxt[k*DATA_W +: DATA_W] = bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ch_q    <= '0;
            shadow  <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch_q    <= ch_nxt;
            shadow  <= shadow_nxt;
            valid_q <= done;
            err_q   <= err;
            if (done) frame_q <= shadow_nxt;
        end
    end

    assign bus.out_data  = frame_q;
    assign bus.out_valid = valid_q;
    assign bus.frame_err = err_q;
    assign bus.ch_idx    = ch_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed vector table, hand sequences for
// reset and N_CH=1, then random traffic against a frame model.
module tb_tdm_demux;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdm_demux_if #(.N_CH(4), .DATA_W(8)) bus4 ();
    tdm_demux_if #(.N_CH(1), .DATA_W(8)) bus1 ();

    tdm_demux #(.N_CH(4), .DATA_W(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    tdm_demux #(.N_CH(1), .DATA_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic        ov;
        logic        err;
        logic [31:0] out;
        logic [1:0]  ch;
    } vec_t;

    vec_t tbl[$];

    // Behavioural frame model: count of words collected, 0 = hunting.
    int          m_cnt[2];
    logic [7:0]  m_slot[2][16];
    logic [63:0] m_out[2];
    logic        m_ov[2];
    logic        m_err[2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_cnt[u] = 0;
            m_out[u] = '0;
            m_ov[u]  = 1'b0;
            m_err[u] = 1'b0;
        end
    endtask

    task automatic model_step(input int u, input int n, input logic v,
                              input logic s, input logic [7:0] d);
        m_ov[u]  = 1'b0;
        m_err[u] = 1'b0;
        if (v) begin
            if (s) begin
                if (m_cnt[u] > 0) m_err[u] = 1'b1;
                m_slot[u][0] = d;
                m_cnt[u] = 1;
            end else if (m_cnt[u] == 0) begin
                m_err[u] = 1'b1;
            end else begin
                m_slot[u][m_cnt[u]] = d;
                m_cnt[u]++;
            end
            if (m_cnt[u] == n) begin
                m_out[u] = '0;
                for (int k = 0; k < n; k++) m_out[u][k*8 +: 8] = m_slot[u][k];
                m_ov[u]  = 1'b1;
                m_cnt[u] = 0;
            end
        end
    endtask

    task automatic drive(input logic v4, input logic s4, input logic [7:0] d4,
                         input logic v1, input logic s1, input logic [7:0] d1);
        bus4.in_valid = v4;
        bus4.in_sof   = s4;
        bus4.in_data  = d4;
        bus1.in_valid = v1;
        bus1.in_sof   = s1;
        bus1.in_data  = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " ov4"},  64'(bus4.out_valid), 64'(m_ov[0]));
        chk({tag, " err4"}, 64'(bus4.frame_err), 64'(m_err[0]));
        chk({tag, " out4"}, 64'(bus4.out_data),  m_out[0]);
        chk({tag, " ch4"},  64'(bus4.ch_idx),    64'(m_cnt[0]));
        chk({tag, " ov1"},  64'(bus1.out_valid), 64'(m_ov[1]));
        chk({tag, " err1"}, 64'(bus1.frame_err), 64'(m_err[1]));
        chk({tag, " out1"}, 64'(bus1.out_data),  m_out[1]);
    endtask

    initial begin
        logic v, s;
        logic [7:0] d;
        logic w, t;
        logic [7:0] e;

        tbl.push_back('{1, 1, 8'h11, 0, 0, 32'h0,        2'd1});
        tbl.push_back('{1, 0, 8'h22, 0, 0, 32'h0,        2'd2});
        tbl.push_back('{1, 0, 8'h33, 0, 0, 32'h0,        2'd3});
        tbl.push_back('{1, 0, 8'h44, 1, 0, 32'h44332211, 2'd0});
        tbl.push_back('{1, 1, 8'h11, 0, 0, 32'h44332211, 2'd1});
        tbl.push_back('{1, 0, 8'h22, 0, 0, 32'h44332211, 2'd2});
        tbl.push_back('{0, 0, 8'h99, 0, 0, 32'h44332211, 2'd2});
        tbl.push_back('{0, 1, 8'h98, 0, 0, 32'h44332211, 2'd2});
        tbl.push_back('{1, 0, 8'h33, 0, 0, 32'h44332211, 2'd3});
        tbl.push_back('{1, 0, 8'h44, 1, 0, 32'h44332211, 2'd0});
        tbl.push_back('{1, 1, 8'hAA, 0, 0, 32'h44332211, 2'd1});
        tbl.push_back('{1, 0, 8'hBB, 0, 0, 32'h44332211, 2'd2});
        tbl.push_back('{1, 1, 8'h01, 0, 1, 32'h44332211, 2'd1});
        tbl.push_back('{1, 0, 8'h02, 0, 0, 32'h44332211, 2'd2});
        tbl.push_back('{1, 0, 8'h03, 0, 0, 32'h44332211, 2'd3});
        tbl.push_back('{1, 0, 8'h04, 1, 0, 32'h04030201, 2'd0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 32'h04030201, 2'd0});
        tbl.push_back('{1, 0, 8'h55, 0, 1, 32'h04030201, 2'd0});
        tbl.push_back('{1, 1, 8'h61, 0, 0, 32'h04030201, 2'd1});
        tbl.push_back('{1, 0, 8'h62, 0, 0, 32'h04030201, 2'd2});
        tbl.push_back('{1, 0, 8'h63, 0, 0, 32'h04030201, 2'd3});
        tbl.push_back('{1, 0, 8'h64, 1, 0, 32'h64636261, 2'd0});

        bus4.in_valid = 1'b0;
        bus4.in_sof   = 1'b0;
        bus4.in_data  = '0;
        bus1.in_valid = 1'b0;
        bus1.in_sof   = 1'b0;
        bus1.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out", 64'(bus4.out_data), 64'h0);
        chk("rst ch",  64'(bus4.ch_idx), 64'h0);
        chk("rst ov",  64'(bus4.out_valid), 64'h0);
        chk("rst err", 64'(bus4.frame_err), 64'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, 1'b0, 1'b0, 8'h00);
            chk($sformatf("vec%0d ov", i),  64'(bus4.out_valid), 64'(tbl[i].ov));
            chk($sformatf("vec%0d err", i), 64'(bus4.frame_err), 64'(tbl[i].err));
            chk($sformatf("vec%0d out", i), 64'(bus4.out_data),  64'(tbl[i].out));
            chk($sformatf("vec%0d ch", i),  64'(bus4.ch_idx),    64'(tbl[i].ch));
        end

        drive(1, 1, 8'h11, 0, 0, 8'h00);
        drive(1, 0, 8'h22, 0, 0, 8'h00);
        chk("mid ch", 64'(bus4.ch_idx), 64'd2);
        rst = 1'b1;
        #1;
        chk("async out", 64'(bus4.out_data), 64'h0);
        chk("async ch",  64'(bus4.ch_idx), 64'h0);
        @(posedge clk);
        #1;
        chk("inrst ov",  64'(bus4.out_valid), 64'h0);
        chk("inrst err", 64'(bus4.frame_err), 64'h0);
        rst = 1'b0;
        drive(1, 0, 8'hA2, 0, 0, 8'h00);
        chk("post rst nosof err", 64'(bus4.frame_err), 64'h1);
        drive(1, 1, 8'hA1, 0, 0, 8'h00);
        drive(1, 0, 8'hA2, 0, 0, 8'h00);
        drive(1, 0, 8'hA3, 0, 0, 8'h00);
        chk("a3 ov", 64'(bus4.out_valid), 64'h0);
        drive(1, 0, 8'hA4, 0, 0, 8'h00);
        chk("a4 ov",  64'(bus4.out_valid), 64'h1);
        chk("a4 out", 64'(bus4.out_data), 64'hA4A3A2A1);
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        chk("a4 hold ov",  64'(bus4.out_valid), 64'h0);
        chk("a4 hold out", 64'(bus4.out_data), 64'hA4A3A2A1);

        drive(0, 0, 8'h00, 1, 1, 8'h5A);
        chk("n1 ov",  64'(bus1.out_valid), 64'h1);
        chk("n1 out", 64'(bus1.out_data), 64'h5A);
        chk("n1 err", 64'(bus1.frame_err), 64'h0);
        drive(0, 0, 8'h00, 1, 0, 8'h5B);
        chk("n1 err2", 64'(bus1.frame_err), 64'h1);
        chk("n1 ov2",  64'(bus1.out_valid), 64'h0);
        chk("n1 out2", 64'(bus1.out_data), 64'h5A);
        chk("n1 ch",   64'(bus1.ch_idx), 64'h0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            w = ($urandom_range(0, 9) < 6);
            t = ($urandom_range(0, 2) != 0);
            e = 8'($urandom);
            model_step(0, 4, v, s, d);
            model_step(1, 1, w, t, e);
            drive(v, s, d, w, t, e);
            chk_model($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
